// File: rtl/cic_decim_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the CIC decimator controller.
package cic_pkg;

    localparam int unsigned CIC_STAGES           = 2;
    localparam int unsigned CIC_RATIO_W          = 8;
    localparam int unsigned CIC_DEFAULT_RATIO_M1 = 3;
    localparam int unsigned CIC_DATA_W           = 5;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] cic_state_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WARMUP = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    // Comb output width needed for full-scale growth at the largest ratio in use.
    function automatic int unsigned cic_data_w(input int unsigned stages, input int unsigned max_m);
        return 1 + stages * int'($clog2(max_m));
    endfunction

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Datapath strobes and decimated-sample stream between the controller and its neighbours.
interface cic_decim_ctrl_if
    import cic_pkg::*;
#(
    parameter int unsigned DATA_W = CIC_DATA_W
);
    logic              in_valid;
    logic              integ_en;
    logic              comb_en;
    logic              dp_clr;
    logic [DATA_W-1:0] comb_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  in_valid, comb_data, out_ready,
        output integ_en, comb_en, dp_clr, out_data, out_valid
    );

    modport slave (
        output in_valid, comb_data, out_ready,
        input  integ_en, comb_en, dp_clr, out_data, out_valid
    );
endinterface

// File: rtl/cic_decim_ctrl_out_reg.sv
// One-entry valid/ready holding register for decimated samples with a sticky overrun flag.
module cic_out_reg #(
    parameter int unsigned DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              ready,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overrun
);

    logic load_c;
    logic drop_c;

    // A capture lands if the slot is empty or is being drained this same cycle.
    always_comb begin
        load_c = capture && (!valid || ready);
        drop_c = capture && valid && !ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_c) begin
                data  <= cap_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (drop_c) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: single-clock enables, programmable ratio, comb warm-up
// discard and a handshaked output register.
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned STAGES           = CIC_STAGES,
    parameter int unsigned RATIO_W          = CIC_RATIO_W,
    parameter int unsigned DEFAULT_RATIO_M1 = CIC_DEFAULT_RATIO_M1,
    parameter int unsigned DATA_W           = CIC_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [RATIO_W-1:0] cfg_ratio_m1,
    input  logic               overrun_clr,
    output logic               overrun,
    output logic               busy,
    cic_decim_ctrl_if.master   bus
);

    localparam int unsigned WARM_W = int'($clog2(STAGES + 1));

    cic_state_t          state, state_d;
    logic [RATIO_W-1:0]  ratio;
    logic [RATIO_W-1:0]  phase, phase_d;
    logic [WARM_W-1:0]   warm_cnt, warm_d;
    logic                comb_en_q, comb_en_d;
    logic                cap_q, cap_d;
    logic                dp_clr_q, dp_clr_d;
    logic                busy_d;
    logic                integ_en_c;

    // Samples count only while running with en held, and never in the clear cycle.
    always_comb begin
        integ_en_c = en && bus.in_valid && (state != IDLE) && !dp_clr_q;
    end

    always_comb begin
        state_d   = state;
        phase_d   = phase;
        warm_d    = warm_cnt;
        comb_en_d = 1'b0;
        cap_d     = 1'b0;
        dp_clr_d  = 1'b0;
        busy_d    = 1'b0;
        case (state)
            IDLE: begin
                phase_d = '0;
                warm_d  = '0;
                if (en) begin
                    state_d  = WARMUP;
                    dp_clr_d = 1'b1;
                end
            end
            WARMUP, RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    phase_d = '0;
                    warm_d  = '0;
                end else begin
                    if (integ_en_c) begin
                        if (phase == ratio) begin
                            phase_d   = '0;
                            comb_en_d = 1'b1;
                        end else begin
                            phase_d = phase + RATIO_W'(1);
                        end
                    end
                    // Only comb outputs produced after warm-up reach the output register.
                    cap_d = comb_en_q && (state == RUN);
                    if ((state == WARMUP) && comb_en_q) begin
                        warm_d = warm_cnt + WARM_W'(1);
                        if (warm_cnt == WARM_W'(STAGES - 1)) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            warm_cnt  <= '0;
            comb_en_q <= 1'b0;
            cap_q     <= 1'b0;
            dp_clr_q  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            warm_cnt  <= warm_d;
            comb_en_q <= comb_en_d;
            cap_q     <= cap_d;
            dp_clr_q  <= dp_clr_d;
            busy      <= busy_d;
        end
    end

    // Ratio may only change while the datapath is parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            ratio <= RATIO_W'(DEFAULT_RATIO_M1);
        end else if (cfg_load && (state == IDLE)) begin
            ratio <= cfg_ratio_m1;
        end
    end

    assign bus.integ_en = integ_en_c;
    assign bus.comb_en  = comb_en_q;
    assign bus.dp_clr   = dp_clr_q;

    cic_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .capture     (cap_q),
        .cap_data    (bus.comb_data),
        .ready       (bus.out_ready),
        .overrun_clr (overrun_clr),
        .data        (bus.out_data),
        .valid       (bus.out_valid),
        .overrun     (overrun)
    );

endmodule
